fft_bitrev_buffer: RTL and testbench

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_bitrev_buffer_pkg.sv | 31 +++
 rtl/fft_bitrev_buffer_ram.sv | 39 +++
 rtl/fft_bitrev_buffer.sv | 128 ++++++++++++
 tb/tb_fft_bitrev_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_buffer_pkg.sv
// Shared FFT types: complex floating-point sample layout, reader states and
// the bit-reversal index helper used by the reorder stages.
package fft_bitrev_buffer_pkg;

    localparam int I_EXP  = 8;
    localparam int I_MNT  = 23;
    localparam int I_DATA = 1 + I_EXP + I_MNT;

    typedef struct packed {
        logic [I_DATA-1:0] r;
        logic [I_DATA-1:0] i;
    } complex_fp_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_e;

    // Reverse the low log2n bits of idx; bits above log2n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned log2n);
        logic [31:0] rev;
        rev = 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (b < int'(log2n)) begin
                rev[b] = idx[int'(log2n) - 1 - b];
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_bitrev_buffer_ram.sv
// One ping-pong bank: synchronous write port, registered read port.
// Only the read register is reset; the storage array keeps its contents.
module cplx_bank_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Natural-order to bit-reversed-order frame reorder buffer in front of the
// first butterfly stage, built from two ping-pong banks.
module fft_bitrev_buffer
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int LOG2N    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  complex_fp_t in_data,
    output logic        in_ready,
    output logic        out_valid,
    output complex_fp_t out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        sync_err
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             wr_full_q, wr_full_d, bank_sel_q, bank_sel_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             sync_err_q, sync_err_d;
    logic             out_valid_q, out_sof_q, out_eof_q, rd_bank_q;

    logic             swap, accept, resync, wr_bank, rd_en;
    logic [LOG2N-1:0] wr_addr, rd_addr;
    logic [2*I_DATA-1:0] rdata0, rdata1;

    // Handshake, swap decision and bank addressing
    always_comb begin
        swap    = wr_full_q && ((rd_state_q == R_IDLE) ||
                                (rd_state_q == R_DRAIN && rd_cnt_q == LAST));
        in_ready = reset | ~wr_full_q | swap;
        accept  = in_valid & in_ready & ~reset;
        resync  = accept & in_sof & (wr_cnt_q != '0) & ~swap;
        wr_bank = bank_sel_q ^ swap;
        wr_addr = (swap | resync) ? '0 : wr_cnt_q;
        rd_en   = (rd_state_q == R_DRAIN);
        rd_addr = LOG2N'(bitrev(32'(rd_cnt_q), LOG2N));
    end

    // Next-state logic for writer and reader
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_full_d  = wr_full_q;
        bank_sel_d = bank_sel_q;
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        sync_err_d = sync_err_q | resync;
        if (swap) begin
            // The just-filled bank becomes the read bank; a sample taken now
            // lands at address 0 of the other bank.
            bank_sel_d = ~bank_sel_q;
            wr_full_d  = 1'b0;
            wr_cnt_d   = accept ? LOG2N'(1) : '0;
            rd_state_d = R_DRAIN;
            rd_cnt_d   = '0;
        end else begin
            if (accept) begin
                wr_cnt_d  = wr_addr + LOG2N'(1);
                wr_full_d = (wr_addr == LAST);
            end else begin
                wr_cnt_d  = wr_cnt_q;
            end
            if (rd_state_q == R_DRAIN) begin
                if (rd_cnt_q == LAST) begin
                    rd_state_d = R_IDLE;
                    rd_cnt_d   = '0;
                end else begin
                    rd_cnt_d   = rd_cnt_q + LOG2N'(1);
                end
            end else begin
                rd_cnt_d = rd_cnt_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            wr_full_q   <= 1'b0;
            bank_sel_q  <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_cnt_q    <= '0;
            sync_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_full_q   <= wr_full_d;
            bank_sel_q  <= bank_sel_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            sync_err_q  <= sync_err_d;
            out_valid_q <= rd_en;
            out_sof_q   <= rd_en && (rd_cnt_q == '0);
            out_eof_q   <= rd_en && (rd_cnt_q == LAST);
            rd_bank_q   <= rd_en ? ~bank_sel_q : rd_bank_q;
        end
    end

    cplx_bank_ram #(.DEPTH(N_POINTS), .AW(LOG2N), .W(2*I_DATA)) u_bank0 (
        .clk(clk), .reset(reset),
        .we(accept & ~wr_bank), .waddr(wr_addr), .wdata(in_data),
        .re(rd_en & bank_sel_q), .raddr(rd_addr), .rdata(rdata0)
    );

    cplx_bank_ram #(.DEPTH(N_POINTS), .AW(LOG2N), .W(2*I_DATA)) u_bank1 (
        .clk(clk), .reset(reset),
        .we(accept & wr_bank), .waddr(wr_addr), .wdata(in_data),
        .re(rd_en & ~bank_sel_q), .raddr(rd_addr), .rdata(rdata1)
    );

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign sync_err  = sync_err_q;
    assign out_data  = complex_fp_t'(rd_bank_q ? rdata1 : rdata0);

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Bench for fft_bitrev_buffer at N_POINTS = 8: vector table, directed corner
// sequences and a random soak against a frame-level reference model.
module tb_fft_bitrev_buffer;
    import fft_bitrev_buffer_pkg::*;

    localparam int N  = 8;
    localparam int LG = 3;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_sof, in_ready;
    logic        out_valid, out_sof, out_eof, sync_err;
    complex_fp_t in_data, out_data;

    always #5 clk = ~clk;

    fft_bitrev_buffer #(.N_POINTS(N), .LOG2N(LG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .sync_err(sync_err)
    );

    typedef struct { complex_fp_t d; logic sof; logic eof; } exp_t;
    typedef struct { logic [31:0] in_r; logic [31:0] exp_r; logic sof; logic eof; } vec_t;

    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, run = 0, max_run = 0, stalls = 0;
    int          full_edge = 0, sof_edge = 0;
    complex_fp_t part_q[$];
    exp_t        exp_q[$];
    complex_fp_t cap_q[$];
    logic        cap_sof_q[$], cap_eof_q[$];
    logic        exp_serr = 1'b0, rst_prev = 1'b0, prev_valid = 1'b0, prev_eof = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit reversal by repeated halving, independent of any bit slicing.
    function automatic int rev(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and output monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_out_data", out_data, 64'd0);
        end
        if (prev_valid && !prev_eof && !rst_prev)
            check("drain_contiguous", 64'(out_valid), 64'd1);
        if (out_valid) begin
            cap_q.push_back(out_data);
            cap_sof_q.push_back(out_sof);
            cap_eof_q.push_back(out_eof);
            if (out_sof) sof_edge = cyc;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: got %0h, expected no output (t=%0t)", out_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.d);
                check("out_sof", 64'(out_sof), 64'(e.sof));
                check("out_eof", 64'(out_eof), 64'(e.eof));
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        check("sync_err", 64'(sync_err), 64'(exp_serr));
        prev_valid = out_valid;
        prev_eof   = out_eof;
        if (reset) begin
            part_q.delete();
            exp_q.delete();
            exp_serr = 1'b0;
        end else if (in_valid && in_ready) begin
            if (in_sof && part_q.size() != 0) begin
                exp_serr = 1'b1;
                part_q.delete();
            end
            part_q.push_back(in_data);
            if (part_q.size() == N) begin
                for (int k = 0; k < N; k++)
                    exp_q.push_back('{d: part_q[rev(k)], sof: (k == 0), eof: (k == N - 1)});
                part_q.delete();
                full_edge = cyc + 1;
            end
        end
        rst_prev = reset;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input complex_fp_t d, input logic sof);
        int guard = 0;
        in_valid = 1'b1; in_data = d; in_sof = sof;
        while (!in_ready && guard < 100) begin
            tick(1);
            guard++;
            stalls++;
        end
        if (guard == 100) begin
            n_checks++; n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 100 cycles, expected 1");
        end
        tick(1);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            tick(1);
            guard++;
        end
        tick(2);
        if (guard == 200) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending outputs, expected 0", exp_q.size());
        end
    endtask

    task automatic clear_cap();
        cap_q.delete(); cap_sof_q.delete(); cap_eof_q.delete();
    endtask

    function automatic complex_fp_t rnd_sample();
        complex_fp_t s;
        s.r = $urandom;
        s.i = $urandom;
        return s;
    endfunction

    logic [31:0] flt [N];
    int          exp_idx [N];
    vec_t        tbl [N];

    initial begin
        complex_fp_t s;
        int k;
        flt = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};
        exp_idx = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < N; i++)
            tbl[i] = '{in_r: flt[i], exp_r: flt[exp_idx[i]], sof: (i == 0), eof: (i == N - 1)};

        // Reset: outputs cleared, in_ready high, nothing accepted
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        tick(1);
        in_valid = 1'b1; in_data = rnd_sample();
        tick(1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sof", 64'(out_sof), 64'd0);
        check("rst_out_eof", 64'(out_eof), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        in_valid = 1'b0; reset = 1'b0;
        tick(3);

        // Single frame from the vector table
        clear_cap();
        for (int i = 0; i < N; i++) begin
            s.r = tbl[i].in_r;
            s.i = 32'(i * 17);
            send(s, 1'b1 && (i == 0));
        end
        wait_drain();
        check("tbl_count", 64'(cap_q.size()), 64'(N));
        if (cap_q.size() == N) begin
            for (int i = 0; i < N; i++) begin
                check("tbl_out_r", 64'(cap_q[i].r), 64'(tbl[i].exp_r));
                check("tbl_out_sof", 64'(cap_sof_q[i]), 64'(tbl[i].sof));
                check("tbl_out_eof", 64'(cap_eof_q[i]), 64'(tbl[i].eof));
            end
        end
        check("tbl_latency", 64'(sof_edge - full_edge), 64'd2);

        // Three back-to-back frames with in_valid held
        max_run = 0; stalls = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) send(rnd_sample(), i == 0);
        wait_drain();
        check("b2b_stalls", 64'(stalls), 64'd0);
        check("b2b_valid_run", 64'(max_run), 64'(3 * N));

        // Throttled input, one sample in three cycles
        max_run = 0; stalls = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) begin
                send(rnd_sample(), i == 0);
                tick(2);
            end
        wait_drain();
        check("thr_stalls", 64'(stalls), 64'd0);
        check("thr_valid_run", 64'(max_run), 64'(N));

        // Early in_sof after a partial frame
        clear_cap();
        for (int i = 0; i < 5; i++) send(rnd_sample(), i == 0);
        for (int i = 0; i < N; i++) send(rnd_sample(), i == 0);
        wait_drain();
        check("resync_sync_err", 64'(sync_err), 64'd1);
        check("resync_count", 64'(cap_q.size()), 64'(N));
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
        check("resync_cleared", 64'(sync_err), 64'd0);

        // Reset in the middle of a drain, then a fresh frame
        clear_cap();
        for (int i = 0; i < N; i++) send(rnd_sample(), i == 0);
        tick(4);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("middrain_out_valid", 64'(out_valid), 64'd0);
        check("middrain_count", 64'(cap_q.size()), 64'd3);
        tick(12);
        check("middrain_no_more", 64'(cap_q.size()), 64'd3);
        for (int i = 0; i < N; i++) send(rnd_sample(), i == 0);
        wait_drain();
        check("postrst_count", 64'(cap_q.size()), 64'(3 + N));
        check("postrst_latency", 64'(sof_edge - full_edge), 64'd2);

        // Random soak with stalls and occasional misplaced in_sof
        k = 0;
        for (int n = 0; n < 1200; n++) begin
            if (k != 0 && $urandom_range(0, 39) == 0) begin
                send(rnd_sample(), 1'b1);
                k = 1;
            end else begin
                send(rnd_sample(), (k == 0) && ($urandom_range(0, 1) == 1));
                k = (k + 1) % N;
            end
            tick($urandom_range(0, 2));
        end
        while (k != 0) begin
            send(rnd_sample(), 1'b0);
            k = (k + 1) % N;
        end
        wait_drain();
        check("soak_all_delivered", 64'(exp_q.size()), 64'd0);
        check("soak_no_partial", 64'(part_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
